// File: rtl/main_mem_responder.sv
// Word-addressed backing memory for the data cache's miss/write-through port.
// It services one request at a time and responds after a fixed read or write latency.
module main_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned READ_LAT  = 4,
  parameter int unsigned WRITE_LAT = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  output logic        mem_wack,
  output logic        mem_err
);

  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RD = 2'd1,
    WAIT_WR = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             err_q;

  logic [31:0] array [DEPTH];

  logic [31:0] offset;
  logic        addr_bad;
  logic        done;

  // Unsigned compare catches addresses below the base before the subtraction can wrap.
  assign offset   = mem_addr - BASE_ADDR;
  assign addr_bad = (mem_addr[1:0] != 2'b00) || (mem_addr < BASE_ADDR) ||
                    ((offset >> 2) >= 32'(DEPTH));
  assign done     = (state != IDLE) && (cnt == '0);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_ready = (state == IDLE);
    unique case (state)
      IDLE: begin
        if (mem_req) begin
          state_nxt = mem_we ? WAIT_WR : WAIT_RD;
          cnt_nxt   = mem_we ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
        end
      end
      WAIT_RD, WAIT_WR: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      mem_rvalid <= 1'b0;
      mem_wack   <= 1'b0;
      mem_err    <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      mem_rvalid <= done && (state == WAIT_RD);
      mem_wack   <= done && (state == WAIT_WR);
      mem_err    <= done && err_q;
      if (state == IDLE && mem_req) begin
        idx_q   <= offset[IDX_W+1:2];
        wdata_q <= mem_wdata;
        err_q   <= addr_bad;
      end
      if (done && state == WAIT_RD) begin
        mem_rdata <= err_q ? ERR_DATA : array[idx_q];
      end
    end
  end

  // NOTE: the array is deliberately not reset so it maps onto block RAM; an aborted write never reaches
  // it because reset forces the state out of WAIT_WR.
  always_ff @(posedge clk) begin
    if (done && state == WAIT_WR && !err_q) begin
      array[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomised scoreboard bench for main_mem_responder: the driver queues expected responses
// from a word-array model and an independent monitor checks every response pulse.
module tb_main_mem_responder;

  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned READ_LAT  = 4;
  localparam int unsigned WRITE_LAT = 2;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          KNOWN     = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_wack;
  logic        mem_err;

  main_mem_responder #(
    .DEPTH(DEPTH), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_wack(mem_wack), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          cyc    = 0;
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [31:0] last_rd = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a < BASE) || ((a - BASE) / 4 >= DEPTH);
  endfunction

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_n) last_rd = '0;
    if (mem_rvalid || mem_wack || mem_err) begin
      check("pulse_excl", 32'(mem_rvalid & mem_wack), 0);
      check("err_alone", 32'(mem_err & ~(mem_rvalid | mem_wack)), 0);
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'(sb.size()), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_kind", 32'(mem_rvalid), 32'(e.is_rd));
        check("resp_err", 32'(mem_err), 32'(e.err));
        check("resp_cycle", cyc, e.cyc);
        if (e.is_rd) begin
          check("rdata", mem_rdata, e.data);
          last_rd = e.data;
        end else begin
          check("rdata_hold", mem_rdata, last_rd);
        end
      end
    end
  end

  // Issues one request starting at a negedge and returns at the negedge where mem_ready is back.
  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit hold, input bit scramble);
    int   n;
    int   lat;
    exp_t e;
    mem_req   = 1'b1;
    mem_we    = we;
    mem_addr  = addr;
    mem_wdata = wdata;
    n = 0;
    while (!mem_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!mem_ready) begin
      check("ready_timeout", 32'(mem_ready), 1);
      mem_req = 1'b0;
      return;
    end
    lat     = we ? WRITE_LAT : READ_LAT;
    e.is_rd = !we;
    e.err   = model_bad(addr);
    e.cyc   = cyc + 1 + lat;
    e.data  = (!we && !e.err) ? model[int'((addr - BASE) / 4)] : 32'hDEAD_BEEF;
    if (we && !e.err) model[int'((addr - BASE) / 4)] = wdata;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) mem_req = 1'b0;
    if (scramble) begin
      mem_addr  = addr ^ 32'h4;
      mem_wdata = ~wdata;
    end
    n = 0;
    while (!mem_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_cycles", n, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          k;
    int          idx;
    logic [31:0] a;
    rst_n = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    #1 rst_n = 1'b0;

    // Reset then idle.
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(mem_ready), 1);
    check("rst_rvalid", 32'(mem_rvalid), 0);
    check("rst_wack", 32'(mem_wack), 0);
    check("rst_err", 32'(mem_err), 0);
    check("rst_rdata", mem_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(mem_ready), 1);

    // Write then read back.
    do_req(1'b1, 32'h40, 32'hCAFE_F00D, 1'b0, 1'b0);
    do_req(1'b0, 32'h40, 32'h0, 1'b0, 1'b0);

    // Fill the region used by the random phase.
    for (int i = 0; i < KNOWN; i++) do_req(1'b1, 32'(i * 4) + BASE, $urandom, 1'b0, 1'b0);

    // Held request across read, read, write.
    do_req(1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
    do_req(1'b0, 32'h20, 32'h0, 1'b1, 1'b0);
    do_req(1'b1, 32'h30, 32'h5A5A_0001, 1'b1, 1'b0);
    mem_req = 1'b0;

    // Inputs changed right after accept: only the latched address/data may land.
    do_req(1'b1, 32'h18, 32'h0BAD_CAFE, 1'b0, 1'b1);
    do_req(1'b0, 32'h18, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 32'h1C, 32'h0, 1'b0, 1'b0);

    // Bad addresses.
    do_req(1'b0, 32'h2, 32'h0, 1'b0, 1'b0);
    do_req(1'b0, 32'(DEPTH * 4), 32'h0, 1'b0, 1'b0);
    do_req(1'b1, 32'(DEPTH * 4), 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_req(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset in the middle of a write aborts it.
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h80; mem_wdata = 32'h1234_5678;
    @(negedge clk);
    check("midwr_accepted", 32'(mem_ready), 0);
    mem_req = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    check("midwr_rst_ready", 32'(mem_ready), 1);
    check("midwr_rst_rdata", mem_rdata, 0);
    rst_n = 1'b1;
    check("midwr_release_ready", 32'(mem_ready), 1);
    do_req(1'b0, 32'h80, 32'h0, 1'b0, 1'b0);

    // Random mix of good writes, good reads and bad addresses.
    for (int i = 0; i < 60; i++) begin
      k   = $urandom_range(0, 3);
      idx = $urandom_range(0, KNOWN - 1);
      a   = 32'(idx * 4) + BASE;
      case (k)
        0: do_req(1'b1, a, $urandom, 1'b0, 1'($urandom_range(0, 1)));
        1: do_req(1'b0, a, $urandom, 1'b0, 1'($urandom_range(0, 1)));
        2: do_req(1'($urandom_range(0, 1)), a | 32'($urandom_range(1, 3)), $urandom, 1'b0, 1'b0);
        default: do_req(1'($urandom_range(0, 1)), 32'(DEPTH * 4) + 32'($urandom_range(0, 4000) * 4),
                        $urandom, 1'b0, 1'b0);
      endcase
    end

    repeat (10) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Backing main-memory model and responder for the data cache's miss/write-through port.
- Services one outstanding word read or write at a time, with a fixed, parameterised latency.
- Closes the cache's memory side: it accepts address, data and write-enable, and returns read data plus a completion pulse.
- Sits below the cache in the RV32I core memory hierarchy. Used in simulation and on FPGA as block RAM.

Parameters:
- DEPTH, 1024: number of 32-bit words stored.
- READ_LAT, 4: cycles from request accept to read response; must be at least 1.
- WRITE_LAT, 2: cycles from request accept to array update and write ack; must be at least 1.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mem_req  in  1  request valid from cache
- mem_we  in  1  1 = write, 0 = read (cache wr_mem)
- mem_addr  in  32  byte address (cache_to_mem_address)
- mem_wdata  in  32  write data (cache_to_mem_data)
- mem_ready  out  1  responder idle; request accepted at an edge where mem_req && mem_ready
- mem_rvalid  out  1  one-cycle pulse: mem_rdata valid
- mem_rdata  out  32  read data (mem_to_cache_data)
- mem_wack  out  1  one-cycle pulse: write committed
- mem_err  out  1  one-cycle pulse, coincident with mem_rvalid or mem_wack, for a bad address

Behaviour:
- Reset (async assert, sync release), applied whatever the current state:
  - state = IDLE, mem_ready = 1, mem_rvalid = 0, mem_wack = 0, mem_err = 0, mem_rdata = 0, counter = 0.
  - Array contents are not reset.
- Reset asserted mid-transaction aborts it: no array write, no response pulse.
- FSM states are IDLE, WAIT_RD, WAIT_WR.
- IDLE:
  - mem_ready = 1.
  - On edge E0 with mem_req = 1: latch mem_we, mem_addr, mem_wdata, and compute the error flag.
  - Load the counter with READ_LAT-1 (read) or WRITE_LAT-1 (write).
  - Go to WAIT_RD or WAIT_WR; mem_ready = 0 from E0.
- Inputs are sampled only at acceptance. Changes to them while busy are ignored.
- mem_req while mem_ready = 0 is not queued. The cache must hold mem_req until accepted.
- WAIT_RD / WAIT_WR:
  - Counter decrements each edge.
  - At the edge where the counter is 0 (edge E0+LAT), perform the access, pulse the response for the following cycle, and return to IDLE with mem_ready = 1 in that same cycle.
  - The next request can be accepted at edge E0+LAT+1. Back-to-back throughput is LAT+1 cycles per transaction.
- Read response:
  - mem_rdata = array[(mem_addr-BASE_ADDR)>>2] as of the response edge.
  - mem_rdata holds its value until the next read response.
- Write response:
  - Array word is written at the response edge.
  - A read accepted afterwards returns the new value.
- Error condition: mem_addr[1:0] != 0, or mem_addr < BASE_ADDR, or word index >= DEPTH.
  - No array access.
  - Read: mem_rdata = 32'hDEAD_BEEF.
  - mem_err pulses together with mem_rvalid or mem_wack.
- Address arithmetic is 32-bit unsigned; the word index uses bits [clog2(DEPTH)+1:2] after the base subtraction.
- Pulse outputs are 1 cycle only. mem_rvalid and mem_wack are never high together.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> mem_ready = 1, all pulses 0, mem_rdata = 0; release -> mem_ready stays 1.
- Write then read: write 0x0000_0040 = 32'hCAFE_F00D accepted at edge 0 -> mem_wack pulse after edge 2, mem_ready low during edges 1..2. Read of 0x40 accepted at edge 3 -> mem_rvalid after edge 7 with mem_rdata = 32'hCAFE_F00D, mem_err = 0.
- Held request while busy: mem_req held high continuously for read, read, write -> exactly 3 acceptances spaced READ_LAT+1 or WRITE_LAT+1 cycles apart; no extra responses.
- Input change after accept: mem_addr/mem_wdata changed in the cycle after a write is accepted -> array updated with the originally latched address and data only.
- Bad address: read at 0x0000_0002 (misaligned) and read at byte address 4*DEPTH (0x1000) -> each gives mem_rvalid + mem_err pulse with mem_rdata = 32'hDEAD_BEEF. Write at 0x1000 -> mem_wack + mem_err; word 0 is unchanged.
- Reset mid-write: write 0x80 = 32'h1234_5678 accepted, rst_n pulsed low before the counter expires -> no mem_wack. A subsequent read of 0x80 returns the pre-existing value; mem_ready = 1 immediately after release.
